load_ext_unit: RTL and testbench
================================

# load_ext_unit

Sequential load-data unit between the core's memory stage and the data bus. It accepts a load request (byte address plus funct3-style size/sign selector) and issues one or two aligned bus reads. It then extracts the addressed bytes, sign- or zero-extends them to DATA_W, and returns the result over a valid/ready handshake. It extends the combinational byte/half/word extender with a parametrised width, double-word support on 64-bit builds, split handling of boundary-crossing loads, and error reporting.

## Interface
- DATA_W, 32: bus and result width; 32 or 64.
- MISALIGNED, 1: 1 = boundary-crossing loads are split into two bus beats; 0 = they return an error with no bus access.
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- req_valid_i  in  1  load request valid.
- req_ready_o  out  1  unit idle and accepting.
- req_addr_i  in  32  byte address.
- req_sel_i  in  3  000 B, 001 H, 010 W, 011 D (DATA_W=64 only), 100 BU, 101 HU, 110 WU (DATA_W=64 only).
- mem_valid_o  out  1  bus read request.
- mem_ready_i  in  1  bus accepts the request.
- mem_addr_o  out  32  aligned address: low log2(DATA_W/8) bits are 0.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  DATA_W  read data.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- res_data_o  out  DATA_W  extended load data.
- res_err_o  out  1  illegal selector, or crossing load with MISALIGNED=0.

## Operation
- Derived values:
  - B = DATA_W/8.
  - off = req_addr_i mod B.
  - size = 1 << req_sel_i[1:0].
  - Crossing when off + size > B.
- Illegal selectors:
  - 111 for any DATA_W.
  - 011 and 110 when DATA_W=32.
- States: IDLE, REQ0, RSP0, REQ1, RSP1, DONE.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i, latch addr, sel and off.
  - Illegal selector, or crossing with MISALIGNED=0: go to DONE with res_data_o=0 and res_err_o=1.
  - Otherwise go to REQ0.
- REQ0:
  - mem_valid_o=1, mem_addr_o = addr with low bits cleared.
  - Hold until mem_ready_i, then go to RSP0.
- RSP0:
  - On mem_rvalid_i, store the beat as word0.
  - Crossing: go to REQ1. Otherwise go to DONE.
- REQ1: as REQ0, with mem_addr_o = aligned addr + B, wrapping modulo 2^32; then go to RSP1.
- RSP1: on mem_rvalid_i, store the beat as word1 and go to DONE.
- Extraction: raw = ({word1, word0} >> 8*off), low size bytes kept.
  - word1 = 0 for non-crossing loads.
- Extension:
  - sel[2]=0: sign-extend from bit 8*size-1.
  - sel[2]=1: zero-extend.
  - D and full-width W pass through unchanged.
- DONE:
  - res_valid_o=1; res_data_o and res_err_o are registered and stable.
  - On res_ready_i, go to IDLE.
- mem_rvalid_i is ignored outside RSP0/RSP1. The bus holds one outstanding read.
- Results return in request order; only one load is in flight.

## Timing
- Reset values:
  - State IDLE.
  - req_ready_o=1, mem_valid_o=0, mem_addr_o=0.
  - res_valid_o=0, res_data_o=0, res_err_o=0.
  - Internal words 0.
- Reset mid-operation:
  - Abandons any request; the bus sees mem_valid_o drop immediately.
  - A late mem_rvalid_i after reset is ignored.
- Request acceptance cycle T, with bus ready and data in the earliest cycles:
  - Aligned load: mem_valid_o at T+1, rvalid accepted T+2, res_valid_o T+3.
  - Split load: REQ0 T+1, RSP0 T+2, REQ1 T+3, RSP1 T+4, res_valid_o T+5.
  - Error: res_valid_o T+1, no bus activity.
- mem_valid_o and mem_addr_o are stable while mem_ready_i=0.
- res_valid_o, res_data_o and res_err_o are stable while res_ready_i=0.
- req_ready_o=0 in every state except IDLE. A request accepted in IDLE never overlaps a result in DONE.
- Back-to-back throughput:
  - The next request is accepted the cycle after the result handshake (DONE→IDLE).
  - Minimum period per aligned load is 4 cycles.

## Test plan
- Sign-extended byte: DATA_W=32, LB, addr 0x1003, rdata 0x80AABBCC → mem_addr_o 0x1000, res_data_o 0xFFFFFF80, err 0.
- Split zero-extended half: LHU, addr 0x1003, rdata0 0x12AABBCC, rdata1 0x00000034.
  - Beats at 0x1000 then 0x1004.
  - res_data_o 0x00003412.
- Address wrap: LW, addr 0xFFFFFFFE, rdata0 0xBEEF0000, rdata1 0x0000CAFE → second beat addr 0x00000000, res_data_o 0xCAFEBEEF.
- Error paths, all with res_err_o=1 and res_data_o=0 at T+1, mem_valid_o never asserted:
  - MISALIGNED=0, LW, addr 0x1001.
  - sel 111.
  - DATA_W=32, sel 011.
- 64-bit build and backpressure: DATA_W=64, LWU, addr 0x8004, rdata 0x89ABCDEF00000000.
  - res_data_o 0x0000000089ABCDEF.
  - With res_ready_i low for 5 cycles: all result outputs held, req_ready_o=0.
- Reset mid-load: assert rst_i in RSP0, then pulse mem_rvalid_i after release.
  - All outputs return to reset values.
  - The stray response produces no result.
  - A subsequent LB completes normally.

Source files
------------

// File: rtl/load_ext_unit.sv
// Load-data unit: issues one or two aligned bus reads per load, extracts the
// addressed bytes, sign/zero-extends them and returns the result via valid/ready.
module load_ext_unit #(
  parameter int DATA_W     = 32,
  parameter bit MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  input  logic [2:0]        req_sel_i,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [31:0]       mem_addr_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              res_err_o
);

  localparam int          OFF_W       = $clog2(DATA_W / 8);
  localparam logic [31:0] BEAT_BYTES  = 32'(DATA_W / 8);
  localparam logic [4:0]  BEAT_BYTES5 = 5'(DATA_W / 8);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ0 = 3'd1,
    S_RSP0 = 3'd2,
    S_REQ1 = 3'd3,
    S_RSP1 = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_sel;
  logic [2:0]          w_sel_nxt;
  logic [OFF_W-1:0]    r_off;
  logic [OFF_W-1:0]    w_off_nxt;
  logic                r_cross;
  logic                w_cross_nxt;
  logic [DATA_W-1:0]   r_word0;
  logic [DATA_W-1:0]   w_word0_nxt;
  logic [DATA_W-1:0]   r_word1;
  logic [DATA_W-1:0]   w_word1_nxt;
  logic [31:0]         r_mem_addr;
  logic [31:0]         w_mem_addr_nxt;
  logic                r_mem_valid;
  logic                r_req_ready;
  logic                r_res_valid;
  logic [DATA_W-1:0]   r_res_data;
  logic [DATA_W-1:0]   w_res_data_nxt;
  logic                r_res_err;
  logic                w_res_err_nxt;

  logic [OFF_W-1:0]    w_req_off;
  logic [31:0]         w_req_aligned;
  logic [4:0]          w_req_size;
  logic                w_req_cross;
  logic                w_req_illegal;

  // Shift the two-beat window down by the byte offset, then extend from the load size.
  function automatic logic [DATA_W-1:0] f_extract(
    input logic [2*DATA_W-1:0] dw,
    input logic [OFF_W-1:0]    off,
    input logic [2:0]          sel
  );
    logic [DATA_W-1:0] raw;
    logic [DATA_W-1:0] ext;
    logic              sign;
    int                nbits;
    raw = DATA_W'(dw >> {off, 3'b000});
    case (sel[1:0])
      2'b00:   begin nbits = 8;      sign = raw[7];        end
      2'b01:   begin nbits = 16;     sign = raw[15];       end
      2'b10:   begin nbits = 32;     sign = raw[31];       end
      default: begin nbits = DATA_W; sign = raw[DATA_W-1]; end
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      ext[i] = (i < nbits) ? raw[i] : (sign & ~sel[2]);
    end
    return ext;
  endfunction

  // Decode the incoming request: offset, size, boundary crossing and legality.
  always_comb begin
    w_req_off     = req_addr_i[OFF_W-1:0];
    w_req_aligned = {req_addr_i[31:OFF_W], {OFF_W{1'b0}}};
    case (req_sel_i[1:0])
      2'b00:   w_req_size = 5'd1;
      2'b01:   w_req_size = 5'd2;
      2'b10:   w_req_size = 5'd4;
      default: w_req_size = 5'd8;
    endcase
    w_req_cross   = (5'(w_req_off) + w_req_size) > BEAT_BYTES5;
    w_req_illegal = (req_sel_i == 3'b111) ||
                    ((DATA_W == 32) && ((req_sel_i == 3'b011) || (req_sel_i == 3'b110)));
  end

  // Next-state and next-register logic for the load sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_sel_nxt      = r_sel;
    w_off_nxt      = r_off;
    w_cross_nxt    = r_cross;
    w_word0_nxt    = r_word0;
    w_word1_nxt    = r_word1;
    w_mem_addr_nxt = r_mem_addr;
    w_res_data_nxt = r_res_data;
    w_res_err_nxt  = r_res_err;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_sel_nxt   = req_sel_i;
          w_off_nxt   = w_req_off;
          w_cross_nxt = w_req_cross;
          w_word0_nxt = {DATA_W{1'b0}};
          w_word1_nxt = {DATA_W{1'b0}};
          if (w_req_illegal || (w_req_cross && !MISALIGNED)) begin
            w_state_nxt    = S_DONE;
            w_res_data_nxt = {DATA_W{1'b0}};
            w_res_err_nxt  = 1'b1;
          end else begin
            w_state_nxt    = S_REQ0;
            w_mem_addr_nxt = w_req_aligned;
            w_res_err_nxt  = 1'b0;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_REQ0: begin
        if (mem_ready_i) begin
          w_state_nxt = S_RSP0;
        end else begin
          w_state_nxt = S_REQ0;
        end
      end
      S_RSP0: begin
        if (mem_rvalid_i) begin
          w_word0_nxt = mem_rdata_i;
          if (r_cross) begin
            w_state_nxt    = S_REQ1;
            w_mem_addr_nxt = r_mem_addr + BEAT_BYTES;
          end else begin
            w_state_nxt    = S_DONE;
            w_res_data_nxt = f_extract({r_word1, mem_rdata_i}, r_off, r_sel);
          end
        end else begin
          w_state_nxt = S_RSP0;
        end
      end
      S_REQ1: begin
        if (mem_ready_i) begin
          w_state_nxt = S_RSP1;
        end else begin
          w_state_nxt = S_REQ1;
        end
      end
      S_RSP1: begin
        if (mem_rvalid_i) begin
          w_word1_nxt    = mem_rdata_i;
          w_state_nxt    = S_DONE;
          w_res_data_nxt = f_extract({mem_rdata_i, r_word0}, r_off, r_sel);
        end else begin
          w_state_nxt = S_RSP1;
        end
      end
      S_DONE: begin
        if (res_ready_i) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; handshake outputs are registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_sel       <= 3'b000;
      r_off       <= {OFF_W{1'b0}};
      r_cross     <= 1'b0;
      r_word0     <= {DATA_W{1'b0}};
      r_word1     <= {DATA_W{1'b0}};
      r_mem_addr  <= 32'h0000_0000;
      r_mem_valid <= 1'b0;
      r_req_ready <= 1'b1;
      r_res_valid <= 1'b0;
      r_res_data  <= {DATA_W{1'b0}};
      r_res_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sel       <= w_sel_nxt;
      r_off       <= w_off_nxt;
      r_cross     <= w_cross_nxt;
      r_word0     <= w_word0_nxt;
      r_word1     <= w_word1_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_valid <= (w_state_nxt == S_REQ0) || (w_state_nxt == S_REQ1);
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_res_valid <= (w_state_nxt == S_DONE);
      r_res_data  <= w_res_data_nxt;
      r_res_err   <= w_res_err_nxt;
    end
  end

  assign req_ready_o = r_req_ready;
  assign mem_valid_o = r_mem_valid;
  assign mem_addr_o  = r_mem_addr;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_err_o   = r_res_err;

endmodule

// File: tb/tb_load_ext_unit.sv
// Scoreboard bench for load_ext_unit: three builds (32-bit split, 32-bit no-split, 64-bit).
module tb_load_ext_unit;

  typedef struct packed {
    logic [1:0]  k;
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        req_valid  [3];
  logic        req_ready  [3];
  logic [31:0] req_addr   [3];
  logic [2:0]  req_sel    [3];
  logic        mem_valid  [3];
  logic        mem_ready  [3];
  logic [31:0] mem_addr   [3];
  logic        mem_rvalid [3];
  logic [63:0] mem_rdata  [3];
  logic        res_valid  [3];
  logic        res_ready  [3];
  logic        res_err    [3];
  logic [31:0] res_data_a;
  logic [31:0] res_data_b;
  logic [63:0] res_data_c;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  load_ext_unit #(.DATA_W(32), .MISALIGNED(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
    .req_addr_i(req_addr[0]), .req_sel_i(req_sel[0]),
    .mem_valid_o(mem_valid[0]), .mem_ready_i(mem_ready[0]), .mem_addr_o(mem_addr[0]),
    .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0][31:0]),
    .res_valid_o(res_valid[0]), .res_ready_i(res_ready[0]),
    .res_data_o(res_data_a), .res_err_o(res_err[0])
  );

  load_ext_unit #(.DATA_W(32), .MISALIGNED(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
    .req_addr_i(req_addr[1]), .req_sel_i(req_sel[1]),
    .mem_valid_o(mem_valid[1]), .mem_ready_i(mem_ready[1]), .mem_addr_o(mem_addr[1]),
    .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1][31:0]),
    .res_valid_o(res_valid[1]), .res_ready_i(res_ready[1]),
    .res_data_o(res_data_b), .res_err_o(res_err[1])
  );

  load_ext_unit #(.DATA_W(64), .MISALIGNED(1'b1)) u_c (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
    .req_addr_i(req_addr[2]), .req_sel_i(req_sel[2]),
    .mem_valid_o(mem_valid[2]), .mem_ready_i(mem_ready[2]), .mem_addr_o(mem_addr[2]),
    .mem_rvalid_i(mem_rvalid[2]), .mem_rdata_i(mem_rdata[2]),
    .res_valid_o(res_valid[2]), .res_ready_i(res_ready[2]),
    .res_data_o(res_data_c), .res_err_o(res_err[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] get_res(input int k);
    case (k)
      0:       return {32'h0000_0000, res_data_a};
      1:       return {32'h0000_0000, res_data_b};
      default: return res_data_c;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every result handshake pops and compares one expected entry.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (!rst && res_valid[k] && res_ready[k]) begin
        if (sb_q.size() == 0) begin
          chkb("unexpected_result", 1'b1, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("result_unit", 64'(k), 64'(e.k));
          chk("result_data", get_res(k), e.data);
          chkb("result_err", res_err[k], e.err);
        end
      end
    end
  end

  task automatic check_reset_values(input int k);
    chkb("rst_req_ready", req_ready[k], 1'b1);
    chkb("rst_mem_valid", mem_valid[k], 1'b0);
    chk("rst_mem_addr", 64'(mem_addr[k]), 64'h0);
    chkb("rst_res_valid", res_valid[k], 1'b0);
    chk("rst_res_data", get_res(k), 64'h0);
    chkb("rst_res_err", res_err[k], 1'b0);
  endtask

  // Issue one load on unit k, serve nbeats bus reads and consume the result after hold cycles.
  task automatic do_load(input int k, input logic [31:0] addr, input logic [2:0] sel,
                         input int nbeats, input logic [63:0] d0, input logic [63:0] d1,
                         input logic [31:0] a0, input logic [31:0] a1,
                         input logic [63:0] exp_data, input logic exp_err, input int hold);
    exp_t e;
    int   w;
    chkb("req_ready_idle", req_ready[k], 1'b1);
    req_valid[k] = 1'b1;
    req_addr[k]  = addr;
    req_sel[k]   = sel;
    e.k = 2'(k);
    e.err = exp_err;
    e.data = exp_data;
    sb_q.push_back(e);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    if (nbeats == 0) begin
      chkb("err_no_bus", mem_valid[k], 1'b0);
    end
    for (int b = 0; b < nbeats; b++) begin
      w = 0;
      while (!mem_valid[k] && w < 10) begin
        @(posedge clk); #1;
        w++;
      end
      chk("mem_valid_latency", 64'(w), 64'h0);
      chk("mem_addr", 64'(mem_addr[k]), 64'((b == 0) ? a0 : a1));
      mem_ready[k] = 1'b1;
      @(posedge clk); #1;
      mem_ready[k]  = 1'b0;
      mem_rvalid[k] = 1'b1;
      mem_rdata[k]  = (b == 0) ? d0 : d1;
      @(posedge clk); #1;
      mem_rvalid[k] = 1'b0;
      mem_rdata[k]  = 64'h0;
    end
    chkb("res_valid_latency", res_valid[k], 1'b1);
    w = 0;
    while (!res_valid[k] && w < 10) begin
      @(posedge clk); #1;
      w++;
    end
    chkb("req_ready_busy", req_ready[k], 1'b0);
    for (int h = 0; h < hold; h++) begin
      chkb("hold_res_valid", res_valid[k], 1'b1);
      chk("hold_res_data", get_res(k), exp_data);
      chkb("hold_res_err", res_err[k], exp_err);
      chkb("hold_req_ready", req_ready[k], 1'b0);
      chkb("hold_mem_valid", mem_valid[k], 1'b0);
      @(posedge clk); #1;
    end
    res_ready[k] = 1'b1;
    @(posedge clk); #1;
    res_ready[k] = 1'b0;
    chkb("res_valid_drop", res_valid[k], 1'b0);
    chkb("req_ready_back", req_ready[k], 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k]  = 1'b0;
      req_addr[k]   = 32'h0;
      req_sel[k]    = 3'b000;
      mem_ready[k]  = 1'b0;
      mem_rvalid[k] = 1'b0;
      mem_rdata[k]  = 64'h0;
      res_ready[k]  = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) check_reset_values(k);
    rst = 1'b0;
    @(posedge clk); #1;

    // 32-bit unit with split loads
    do_load(0, 32'h0000_1003, 3'b000, 1, 64'h80AA_BBCC, 64'h0, 32'h0000_1000, 32'h0,
            64'hFFFF_FF80, 1'b0, 0);
    do_load(0, 32'h0000_1003, 3'b101, 2, 64'h12AA_BBCC, 64'h0000_0034, 32'h0000_1000,
            32'h0000_1004, 64'h0000_3412, 1'b0, 0);
    do_load(0, 32'hFFFF_FFFE, 3'b010, 2, 64'hBEEF_0000, 64'h0000_CAFE, 32'hFFFF_FFFC,
            32'h0000_0000, 64'hCAFE_BEEF, 1'b0, 0);
    do_load(0, 32'h0000_2002, 3'b001, 1, 64'h8001_0000, 64'h0, 32'h0000_2000, 32'h0,
            64'hFFFF_8001, 1'b0, 0);
    do_load(0, 32'h0000_2001, 3'b100, 1, 64'h0000_F100, 64'h0, 32'h0000_2000, 32'h0,
            64'h0000_00F1, 1'b0, 0);
    do_load(0, 32'h0000_3000, 3'b010, 1, 64'hDEAD_BEEF, 64'h0, 32'h0000_3000, 32'h0,
            64'hDEAD_BEEF, 1'b0, 2);
    do_load(0, 32'h0000_1000, 3'b111, 0, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0, 1'b1, 0);
    do_load(0, 32'h0000_1000, 3'b011, 0, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0, 1'b1, 0);
    do_load(0, 32'h0000_1000, 3'b110, 0, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0, 1'b1, 0);

    // 32-bit unit that rejects crossing loads
    do_load(1, 32'h0000_1001, 3'b010, 0, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0, 1'b1, 0);
    do_load(1, 32'h0000_1004, 3'b010, 1, 64'h1122_3344, 64'h0, 32'h0000_1004, 32'h0,
            64'h1122_3344, 1'b0, 0);

    // 64-bit unit
    do_load(2, 32'h0000_8004, 3'b110, 1, 64'h89AB_CDEF_0000_0000, 64'h0, 32'h0000_8000,
            32'h0, 64'h0000_0000_89AB_CDEF, 1'b0, 5);
    do_load(2, 32'h0000_8004, 3'b010, 1, 64'h89AB_CDEF_0000_0000, 64'h0, 32'h0000_8000,
            32'h0, 64'hFFFF_FFFF_89AB_CDEF, 1'b0, 0);
    do_load(2, 32'h0000_0010, 3'b011, 1, 64'h0123_4567_89AB_CDEF, 64'h0, 32'h0000_0010,
            32'h0, 64'h0123_4567_89AB_CDEF, 1'b0, 0);
    do_load(2, 32'h0000_000C, 3'b011, 2, 64'h7654_3210_0000_0000, 64'h0000_0000_FEDC_BA98,
            32'h0000_0008, 32'h0000_0010, 64'hFEDC_BA98_7654_3210, 1'b0, 0);
    do_load(2, 32'h0000_0000, 3'b111, 0, 64'h0, 64'h0, 32'h0, 32'h0, 64'h0, 1'b1, 0);

    // Reset while waiting for the first beat, then a stray response
    req_valid[0] = 1'b1;
    req_addr[0]  = 32'h0000_1003;
    req_sel[0]   = 3'b000;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chkb("mid_mem_valid", mem_valid[0], 1'b1);
    mem_ready[0] = 1'b1;
    @(posedge clk); #1;
    mem_ready[0] = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_values(0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rvalid[0] = 1'b1;
    mem_rdata[0]  = 64'h80AA_BBCC;
    @(posedge clk); #1;
    mem_rvalid[0] = 1'b0;
    mem_rdata[0]  = 64'h0;
    for (int i = 0; i < 4; i++) begin
      chkb("stray_res_valid", res_valid[0], 1'b0);
      chkb("stray_mem_valid", mem_valid[0], 1'b0);
      chkb("stray_req_ready", req_ready[0], 1'b1);
      @(posedge clk); #1;
    end
    do_load(0, 32'h0000_0000, 3'b000, 1, 64'h1234_567F, 64'h0, 32'h0000_0000, 32'h0,
            64'h0000_007F, 1'b0, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 64'(sb_q.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
